// File: rtl/machine_timer.sv
// RISC-V machine timer: 64-bit mtime behind a programmable prescaler, 64-bit
// mtimecmp, level interrupt; responder on the pre-decoded 20-bit offset bus.
module machine_timer #(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        timer_wr_en_i,
  input  logic [19:0] timer_wr_addr_i,
  input  logic [31:0] timer_wr_data_i,
  input  logic        timer_rd_en_i,
  input  logic [19:0] timer_rd_addr_i,
  output logic [31:0] timer_rd_data_o,
  output logic        timer_irq_o
);

  localparam logic [2:0] IDX_MTIME_LO    = 3'd0;
  localparam logic [2:0] IDX_MTIME_HI    = 3'd1;
  localparam logic [2:0] IDX_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] IDX_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] IDX_CTRL        = 3'd4;
  localparam logic [2:0] IDX_STATUS      = 3'd5;

  logic [63:0]           mtime_q,     mtime_d;
  logic [31:0]           hi_shadow_q, hi_shadow_d;
  logic [63:0]           mtimecmp_q,  mtimecmp_d;
  logic                  en_q,        en_d;
  logic [PRESCALE_W-1:0] prescale_q,  prescale_d;
  logic [PRESCALE_W-1:0] presc_cnt_q, presc_cnt_d;
  logic                  irq_q,       irq_d;

  logic       wr_hit, rd_hit;
  logic [2:0] wr_idx, rd_idx;
  logic       wr_mtime, wr_ctrl;
  logic       tick;
  logic       unused_addr_bits;

  assign unused_addr_bits = ^{timer_wr_addr_i[1:0], timer_rd_addr_i[1:0]};

  assign wr_hit   = timer_wr_en_i && (timer_wr_addr_i[19:5] == '0);
  assign rd_hit   = timer_rd_en_i && (timer_rd_addr_i[19:5] == '0);
  assign wr_idx   = timer_wr_addr_i[4:2];
  assign rd_idx   = timer_rd_addr_i[4:2];
  assign wr_mtime = wr_hit && ((wr_idx == IDX_MTIME_LO) || (wr_idx == IDX_MTIME_HI));
  assign wr_ctrl  = wr_hit && (wr_idx == IDX_CTRL);
  assign tick     = en_q && (presc_cnt_q == prescale_q);

  // Read mux sees current register values; writes in the same cycle land at the edge.
  always_comb begin
    timer_rd_data_o = '0;
    if (rd_hit) begin
      case (rd_idx)
        IDX_MTIME_LO:    timer_rd_data_o = mtime_q[31:0];
        IDX_MTIME_HI:    timer_rd_data_o = hi_shadow_q;
        IDX_MTIMECMP_LO: timer_rd_data_o = mtimecmp_q[31:0];
        IDX_MTIMECMP_HI: timer_rd_data_o = mtimecmp_q[63:32];
        IDX_CTRL: begin
          timer_rd_data_o[0]              = en_q;
          timer_rd_data_o[PRESCALE_W+7:8] = prescale_q;
        end
        IDX_STATUS:      timer_rd_data_o[0] = irq_q;
        default:         timer_rd_data_o = '0;
      endcase
    end
  end

  always_comb begin
    mtime_d     = mtime_q;
    hi_shadow_d = hi_shadow_q;
    mtimecmp_d  = mtimecmp_q;
    en_d        = en_q;
    prescale_d  = prescale_q;
    presc_cnt_d = presc_cnt_q;
    irq_d       = (mtime_q >= mtimecmp_q);

    if (en_q) begin
      presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
    end

    // An mtime write wins over the tick; both mtime and CTRL writes restart the prescaler.
    if (wr_mtime || wr_ctrl) begin
      presc_cnt_d = '0;
    end

    if (wr_mtime) begin
      if (wr_idx == IDX_MTIME_LO) begin
        mtime_d[31:0] = timer_wr_data_i;
      end else begin
        mtime_d[63:32] = timer_wr_data_i;
      end
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    if (wr_hit && (wr_idx == IDX_MTIMECMP_LO)) begin
      mtimecmp_d[31:0] = timer_wr_data_i;
    end
    if (wr_hit && (wr_idx == IDX_MTIMECMP_HI)) begin
      mtimecmp_d[63:32] = timer_wr_data_i;
    end

    if (wr_ctrl) begin
      en_d       = timer_wr_data_i[0];
      prescale_d = timer_wr_data_i[PRESCALE_W+7:8];
    end

    if (rd_hit && (rd_idx == IDX_MTIME_LO)) begin
      hi_shadow_d = mtime_q[63:32];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtime_q     <= '0;
      hi_shadow_q <= '0;
      mtimecmp_q  <= '1;
      en_q        <= 1'b0;
      prescale_q  <= '0;
      presc_cnt_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      hi_shadow_q <= hi_shadow_d;
      mtimecmp_q  <= mtimecmp_d;
      en_q        <= en_d;
      prescale_q  <= prescale_d;
      presc_cnt_q <= presc_cnt_d;
      irq_q       <= irq_d;
    end
  end

  assign timer_irq_o = irq_q;

endmodule

// File: tb/tb_machine_timer.sv
// Scenario bench for machine_timer: expected read values are queued when the
// stimulus is issued and popped as the DUT returns each read.
module tb_machine_timer;

  localparam logic [19:0] A_LO     = 20'h00;
  localparam logic [19:0] A_HI     = 20'h04;
  localparam logic [19:0] A_CMP_LO = 20'h08;
  localparam logic [19:0] A_CMP_HI = 20'h0C;
  localparam logic [19:0] A_CTRL   = 20'h10;
  localparam logic [19:0] A_STAT   = 20'h14;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [19:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic [19:0] rd_addr = '0;
  logic [31:0] rd_data;
  logic        irq;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [19:0] addr;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  machine_timer #(.PRESCALE_W(8)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .timer_wr_en_i   (wr_en),
    .timer_wr_addr_i (wr_addr),
    .timer_wr_data_i (wr_data),
    .timer_rd_en_i   (rd_en),
    .timer_rd_addr_i (rd_addr),
    .timer_rd_data_o (rd_data),
    .timer_irq_o     (irq)
  );

  always #5 clk = ~clk;

  task automatic push(input string n, input logic [19:0] a, input logic [31:0] v);
    exp_t e;
    e.name = n; e.addr = a; e.val = v;
    sb.push_back(e);
  endtask

  // Inputs change 1 unit after a rising edge; each access consumes one edge.
  task automatic wr(input logic [19:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [19:0] a, output logic [31:0] d);
    rd_en = 1'b1; rd_addr = a;
    #1 d = rd_data;
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    exp_t e;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    checks++;
    if (rd_data !== 32'h0) begin errors++; $display("FAIL idle_rd_data: got %h expected 0", rd_data); end
    push("rst_mtime_lo", A_LO, 32'h0);
    push("rst_mtime_hi", A_HI, 32'h0);
    push("rst_cmp_lo", A_CMP_LO, 32'hFFFF_FFFF);
    push("rst_cmp_hi", A_CMP_HI, 32'hFFFF_FFFF);
    push("rst_ctrl", A_CTRL, 32'h0);
    push("rst_status", A_STAT, 32'h0);
    push("unmapped_0x20", 20'h20, 32'h0);
    push("unmapped_0x18", 20'h18, 32'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd(e.addr, d);
      checks++;
      if (d !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, d, e.val); end
    end
  endtask

  task automatic test_prescale();
    logic [31:0] d;
    exp_t e;
    wr(A_CTRL, 32'h0000_0301);
    push("presc3_mtime", A_LO, 32'd4);
    repeat (16) @(posedge clk);
    #1;
    e = sb.pop_front();
    rd(e.addr, d);
    checks++;
    if (d !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, d, e.val); end
    wr(A_CTRL, 32'h1);
    push("presc0_mtime", A_LO, 32'd14);
    repeat (10) @(posedge clk);
    #1;
    e = sb.pop_front();
    rd(e.addr, d);
    checks++;
    if (d !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, d, e.val); end
  endtask

  task automatic test_carry_snapshot();
    logic [31:0] d;
    exp_t e;
    wr(A_CTRL, 32'h0);
    wr(A_HI, 32'h0);
    wr(A_LO, 32'hFFFF_FFFF);
    wr(A_CTRL, 32'h1);
    @(posedge clk); #1;
    push("carry_lo", A_LO, 32'h0);
    push("carry_hi_shadow", A_HI, 32'h1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd(e.addr, d);
      checks++;
      if (d !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, d, e.val); end
    end
    wr(A_HI, 32'h5);
    push("shadow_held", A_HI, 32'h1);
    e = sb.pop_front();
    rd(e.addr, d);
    checks++;
    if (d !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, d, e.val); end
  endtask

  task automatic test_compare_irq();
    logic [31:0] d;
    exp_t e;
    int n;
    wr(A_CTRL, 32'h0);
    wr(A_LO, 32'h100);
    wr(A_HI, 32'h0);
    wr(A_CMP_HI, 32'h0);
    wr(A_CMP_LO, 32'h105);
    wr(A_CTRL, 32'h1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_before_match: got %b expected 0", irq); end
    // mtime reaches 0x105 at the 5th edge; irq registers it at the 6th.
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (irq === 1'b1) begin n = i; break; end
    end
    checks++;
    if (n !== 6) begin errors++; $display("FAIL irq_rise_cycle: got %0d expected 6", n); end
    push("status_irq", A_STAT, 32'h1);
    e = sb.pop_front();
    rd(e.addr, d);
    checks++;
    if (d !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, d, e.val); end
    wr(A_CMP_HI, 32'hFFFF_FFFF);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold_at_write: got %b expected 1", irq); end
    @(posedge clk); #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall: got %b expected 0", irq); end
  endtask

  task automatic test_write_collision();
    logic [31:0] d;
    exp_t e;
    wr(A_LO, 32'h50);
    push("wr_no_tick", A_LO, 32'h50);
    push("wr_next_tick", A_LO, 32'h51);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd(e.addr, d);
      checks++;
      if (d !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, d, e.val); end
    end
    // Unmapped write: neither lands nor suppresses the two ticks that pass.
    wr(20'h00020, 32'h999);
    push("unmapped_wr_dropped", A_LO, 32'h53);
    e = sb.pop_front();
    rd(e.addr, d);
    checks++;
    if (d !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, d, e.val); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    exp_t e;
    wr(A_CTRL, 32'h0);
    wr(A_CMP_HI, 32'h0);
    wr(A_CMP_LO, 32'h10);
    wr(A_HI, 32'h0);
    wr(A_LO, 32'h1234);
    wr(A_CTRL, 32'h1);
    @(posedge clk); #1;
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq: got %b expected 1", irq); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL post_reset_irq: got %b expected 0", irq); end
    push("post_reset_ctrl", A_CTRL, 32'h0);
    push("post_reset_cmp_lo", A_CMP_LO, 32'hFFFF_FFFF);
    for (int i = 0; i < 11; i++) push("post_reset_mtime", A_LO, 32'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd(e.addr, d);
      checks++;
      if (d !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, d, e.val); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    exp_t e;
    // Same-cycle read and write of one register: the read sees the old value.
    push("rw_same_old", A_CMP_LO, 32'hFFFF_FFFF);
    push("rw_same_new", A_CMP_LO, 32'hAAAA_5555);
    e = sb.pop_front();
    wr_en = 1'b1; wr_addr = A_CMP_LO; wr_data = 32'hAAAA_5555;
    rd_en = 1'b1; rd_addr = e.addr;
    #1 d = rd_data;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    checks++;
    if (d !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, d, e.val); end
    e = sb.pop_front();
    rd(e.addr, d);
    checks++;
    if (d !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, d, e.val); end
    wr(A_CTRL, 32'hFFFF_FF01);
    push("ctrl_field_mask", A_CTRL, 32'h0000_FF01);
    e = sb.pop_front();
    rd(e.addr, d);
    checks++;
    if (d !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, d, e.val); end
    wr(A_CTRL, 32'h0);
  endtask

  initial begin
    test_reset();
    test_prescale();
    test_carry_snapshot();
    test_compare_irq();
    test_write_collision();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
